// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one memory read per accepted PC and buffers up
// to two fetched {addr, data} words for decode. A flush discards everything buffered or in flight.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_addr,
    input  logic        flush,
    output logic        fetch_stall,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir_data,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t      state;
    logic [15:0] addr_q [2];
    logic [15:0] data_q [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        slot_free;
    logic        accept;

    // A full queue still has room for a new fetch if decode drains its head this
    // cycle, because the resulting word only lands after the memory acks.
    assign pop         = ir_valid && ir_ready;
    assign slot_free   = (count < 2'd2) || ((count == 2'd2) && pop);
    assign accept      = (state == IDLE) && !flush && slot_free;
    assign fetch_stall = !accept;
    assign push        = (state == REQ) && mem_ack && !flush;

    assign ir_valid = (count != 2'd0);
    assign ir_data  = data_q[rd_ptr];
    assign ir_pc    = addr_q[rd_ptr];

    // Request FSM: the read request is never withdrawn before its ack.
    // A flush mid-request only marks the word to be thrown away in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr <= pc_addr;
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Two-entry FIFO; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= 16'h0000;
                data_q[i] <= 16'h0000;
            end
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= mem_addr;
                data_q[wr_ptr] <= mem_rdata;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port pc_addr, input, 16 bits: fetch address from the program counter.
REQ-004 SHALL have port flush, input, 1 bit: a jump was taken this cycle (jmp or abs); discard all fetched and in-flight words.
REQ-005 SHALL have port fetch_stall, output, 1 bit: high when pc_addr is not accepted this cycle; the program counter holds its value.
REQ-006 SHALL have port mem_req, output, 1 bit: instruction memory read request.
REQ-007 SHALL have port mem_addr, output, 16 bits: read address, stable while mem_req is high.
REQ-008 SHALL have port mem_ack, input, 1 bit: memory read complete; mem_rdata is valid in the same cycle.
REQ-009 SHALL have port mem_rdata, input, 16 bits: instruction word.
REQ-010 SHALL have port ir_valid, output, 1 bit: an instruction is presented to decode.
REQ-011 SHALL have port ir_data, output, 16 bits: instruction word at the queue head.
REQ-012 SHALL have port ir_pc, output, 16 bits: address of ir_data.
REQ-013 SHALL have port ir_ready, input, 1 bit: decode consumes the head entry when ir_valid and ir_ready are both high.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, REQ, DRAIN.
REQ-015 SHALL hold a 2-entry FIFO of {addr, data} pairs and a 2-bit occupancy count (0..2).
REQ-016 SHALL accept pc_addr only in IDLE, with flush low and a free slot; a free slot means count<2, or count==2 with a pop in the same cycle.
REQ-017 On accept, SHALL latch pc_addr into mem_addr, go to REQ and drive mem_req high from the next cycle.
REQ-018 SHALL drive fetch_stall as the combinational inverse of the accept condition.
REQ-019 In REQ, SHALL keep mem_req high and mem_addr constant until mem_ack.
REQ-020 On mem_ack in REQ without flush, SHALL push {mem_addr, mem_rdata}, drop mem_req and return to IDLE.
REQ-021 The minimum cost is one bubble per fetch, so peak throughput is one word per 2 cycles with single-cycle ack.
REQ-022 Ack-to-ir_valid latency SHALL be 1 cycle when the FIFO is empty.
REQ-023 ir_valid SHALL equal (count!=0).
REQ-024 ir_data and ir_pc SHALL reflect the head entry.
REQ-025 A pop (ir_valid and ir_ready) SHALL remove the head entry.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 A push SHALL never occur when count==2; the accept rule guarantees this.
REQ-028 flush SHALL clear the FIFO (count=0) at the next edge, overriding any push or pop in that cycle.
REQ-029 flush in IDLE: SHALL accept nothing that cycle; pc_addr is stale and the new target arrives the next cycle.
REQ-030 flush in REQ without mem_ack: SHALL go to DRAIN with mem_req held high (the request is never withdrawn before ack).
REQ-031 flush in REQ with mem_ack: SHALL discard the word and go to IDLE.
REQ-032 In DRAIN, SHALL keep mem_req high; on mem_ack, SHALL discard the word and go to IDLE.
REQ-033 A further flush during DRAIN SHALL leave the FSM in DRAIN.
REQ-034 mem_ack in IDLE SHALL be ignored.

Reset
REQ-035 rst high SHALL immediately force state=IDLE, count=0, mem_req=0, mem_addr=0x0000, ir_valid=0, ir_data=0x0000, ir_pc=0x0000.
REQ-036 Because reset is asynchronous, a reset mid-transaction SHALL drop mem_req without waiting for mem_ack.
REQ-037 The first accept after rst deasserts SHALL occur on the first edge with pc_addr=0x0000 and fetch_stall=0.

Verification
REQ-038 Basic fetch: pc_addr=0x0000, ir_ready=1, memory acks 1 cycle after req with rdata=0xA001 -> mem_addr=0x0000, then ir_valid=1, ir_data=0xA001, ir_pc=0x0000.
REQ-039 Backpressure: ir_ready=0, three sequential addresses 0x0010/0x0011/0x0012 -> two entries held, fetch_stall=1 stays high, no third mem_req until a pop; order is 0x0010 then 0x0011.
REQ-040 Flush in flight: req to 0x0020, flush before ack, ack 3 cycles later with 0xDEAD -> 0xDEAD never appears on ir_data; next fetch goes to the jump target 0x0100.
REQ-041 Flush with ack in the same cycle: word discarded, FSM returns to IDLE, count=0.
REQ-042 Full push/pop: count=2 with simultaneous pop and new accept -> count ends at 2 and ir_pc sequence is strictly ordered.
REQ-043 Reset mid-REQ: assert rst while mem_req=1 -> mem_req=0 and ir_valid=0 within the same cycle, with no edge needed.
